axis_frame_source: RTL and testbench
====================================

# axis_frame_source

- Drives 128-bit AXI-Stream frames of deterministic 8-bit sample patterns into the beamweight multiplier's slave port (`s_axis_*`).
- Acts as the transmitting end of that interface for bring-up and weight-path verification, replacing the MM2S DMA feed when needed.
- Each `start` produces one frame of `frame_len` beats, with `tlast` on the final beat and full AXI-Stream backpressure handling.

## Interface
Parameters:
- DATA_WIDTH, 128, stream data width in bits.
- SAMPLE_WIDTH, 8, width of one sample lane; NUM_LANES = DATA_WIDTH/SAMPLE_WIDTH (16).
- LEN_WIDTH, 16, width of the frame length (beats).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle frame request; honoured only in IDLE.
- frame_len  in  LEN_WIDTH  beats per frame; sampled with start; 0 means request ignored.
- pattern  in  2  pattern select, sampled with start.
- seed  in  SAMPLE_WIDTH  pattern seed, sampled with start.
- busy  out  1  high from accepted start until last-beat handshake completes.
- frames_sent  out  16  count of completed frames, wraps 0xFFFF->0.
- m_axis_tdata  out  DATA_WIDTH  sample beat; lane k = bits [8k+7:8k], lane 0 at LSB.
- m_axis_tkeep  out  DATA_WIDTH/8  all ones while tvalid, zero otherwise.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  high on final beat of frame only.
- m_axis_tready  in  1  downstream ready.

## Operation
- Reset values: tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, frames_sent=0, state=IDLE, beat counter=0.
- FSM states:
  - IDLE: on start && frame_len!=0, latch frame_len/pattern/seed, clear beat counter n, go to SEND.
  - SEND: present beat n. On handshake (tvalid&&tready): if n==len-1, go to IDLE and increment frames_sent; else n<=n+1 and present next beat.
- Pattern per lane k of beat n (all arithmetic mod 2^SAMPLE_WIDTH):
  - 0 ramp: seed + NUM_LANES*n + k.
  - 1 constant: seed.
  - 2 alternating: seed on even k, ~seed on odd k.
  - 3 beat index: n[SAMPLE_WIDTH-1:0] on every lane.
- tlast = (state==SEND) && (n==len-1); a frame_len=1 frame is a single beat with tlast=1.
- AXIS master rules:
  - tdata/tkeep/tlast/tvalid are registered.
  - Once tvalid is high, outputs hold stable until the handshake.
  - tvalid never depends combinationally on tready.
- Ignored starts: start while busy, or with frame_len==0, has no effect (not queued).
- Start on the last-handshake cycle: busy is still high that cycle, so start is ignored.
- Input changes: frame_len, pattern and seed changes mid-frame have no effect.

## Timing
- Start latency: start sampled at edge E; tvalid=1 with beat 0 after edge E. busy rises after edge E.
- Throughput: one beat per cycle while tready is high; a frame of L beats with tready constant 1 takes exactly L cycles of tvalid.
- Backpressure: tready low holds the current beat, n does not advance, and no beats are skipped or repeated.
- Frame end: after the last-beat handshake edge, tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, and frames_sent is updated.
- Inter-frame gap: the minimum between frames is one idle cycle (start in the first IDLE cycle gives the next beat 0 one cycle later).
- Reset mid-frame: at the next edge with resetn=0, all outputs return to reset values; no tlast is emitted; the partial frame is not counted.

## Test plan
- Reset/idle: hold resetn=0 for 3 cycles, then release with start=0 -> tvalid=0, tkeep=0x0000, busy=0, frames_sent=0 for 10 cycles.
- Ramp frame with no backpressure: tready=1, start with frame_len=4, pattern=0, seed=0x10.
  - Required: 4 consecutive beats.
  - Beat 0 tdata = 0x1F1E..1110 (lane0=0x10).
  - Beat 3 lane0 = 0x40.
  - tlast only on beat 3; frames_sent=1.
- Backpressure: frame_len=3, pattern=3, random tready at 50%.
  - Required: exactly 3 handshakes with lanes 0x00, 0x01, 0x02.
  - tdata is stable throughout every stalled cycle.
- Ignored starts: pulse start mid-frame, and pulse start with frame_len=0 in IDLE -> no extra beats, frames_sent unchanged.
- Single-beat and wrap frames:
  - frame_len=1, pattern=2, seed=0xA5 -> one beat 0x5AA5..5AA5 with tlast=1.
  - Ramp with seed=0xF8 -> lane 8 = 0x00 (wrap).
- Reset mid-frame: assert resetn=0 during beat 2 of an 8-beat frame -> tvalid=0 next cycle, no tlast, frames_sent=0; a subsequent start restarts the frame at beat 0.

Source files
------------

// File: rtl/axis_frame_source_if.sv
// AXI-Stream link between the frame source and the beamweight multiplier.
// The master drives tdata/tkeep/tvalid/tlast and the slave drives tready.
interface axis_frame_source_if #(
   parameter int DATA_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (
      output tdata,
      output tkeep,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/axis_frame_source.sv
// Deterministic AXI-Stream frame generator for weight-path bring-up.
// Each accepted start emits one frame of frame_len registered beats.
module axis_frame_source #(
   parameter int DATA_WIDTH   = 128,
   parameter int SAMPLE_WIDTH = 8,
   parameter int LEN_WIDTH    = 16
) (
   input  logic                    CLK,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [LEN_WIDTH-1:0]    frame_len,
   input  logic [1:0]              pattern,
   input  logic [SAMPLE_WIDTH-1:0] seed,
   output logic                    busy,
   output logic [15:0]             frames_sent,
   axis_frame_source_if.master     m_axis
);

   localparam int NUM_LANES = DATA_WIDTH / SAMPLE_WIDTH;
   localparam int KEEP_W    = DATA_WIDTH / 8;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]              r_state;
   logic [LEN_WIDTH-1:0]    r_len;
   logic [1:0]              r_pat;
   logic [SAMPLE_WIDTH-1:0] r_seed;
   logic [LEN_WIDTH-1:0]    r_n;
   logic [DATA_WIDTH-1:0]   r_tdata;
   logic [KEEP_W-1:0]       r_tkeep;
   logic                    r_tvalid;
   logic                    r_tlast;
   logic [15:0]             r_frames;

   logic                    w_hs;
   logic                    w_accept;
   logic [1:0]              w_sel_pat;
   logic [SAMPLE_WIDTH-1:0] w_sel_seed;
   logic [LEN_WIDTH-1:0]    w_sel_n;
   logic                    w_sel_last;
   logic [SAMPLE_WIDTH-1:0] w_ramp_off;
   logic [SAMPLE_WIDTH-1:0] w_ramp_base;
   logic [DATA_WIDTH-1:0]   w_beat;

   assign w_hs     = r_tvalid & m_axis.tready;
   assign w_accept = (r_state == S_IDLE) & start
                   & (frame_len != '0);

   // Parameters of the beat to be loaded next: a fresh frame
   // takes them from the inputs, otherwise from the latched copy.
   always_comb begin
      w_sel_pat  = r_pat;
      w_sel_seed = r_seed;
      w_sel_n    = r_n + LEN_WIDTH'(1);
      w_sel_last = (w_sel_n == r_len - LEN_WIDTH'(1));
      if (w_accept) begin
         w_sel_pat  = pattern;
         w_sel_seed = seed;
         w_sel_n    = '0;
         w_sel_last = (frame_len == LEN_WIDTH'(1));
      end
   end

   assign w_ramp_off  = SAMPLE_WIDTH'(w_sel_n
                      * LEN_WIDTH'(NUM_LANES));
   assign w_ramp_base = w_sel_seed + w_ramp_off;

   always_comb begin
      w_beat = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         case (w_sel_pat)
            2'd0:
               w_beat[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                  w_ramp_base + SAMPLE_WIDTH'(k);
            2'd1:
               w_beat[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                  w_sel_seed;
            2'd2:
               w_beat[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                  (k % 2 == 1) ? ~w_sel_seed : w_sel_seed;
            default:
               w_beat[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                  w_sel_n[SAMPLE_WIDTH-1:0];
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_len    <= '0;
         r_pat    <= '0;
         r_seed   <= '0;
         r_n      <= '0;
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_frames <= '0;
      end else if (w_accept) begin
         r_state  <= S_SEND;
         r_len    <= frame_len;
         r_pat    <= pattern;
         r_seed   <= seed;
         r_n      <= '0;
         r_tdata  <= w_beat;
         r_tkeep  <= '1;
         r_tvalid <= 1'b1;
         r_tlast  <= w_sel_last;
      end else if (r_state == S_SEND && w_hs) begin
         if (r_tlast) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_frames <= r_frames + 16'd1;
         end else begin
            r_n     <= w_sel_n;
            r_tdata <= w_beat;
            r_tlast <= w_sel_last;
         end
      end
   end

   assign m_axis.tdata  = r_tdata;
   assign m_axis.tkeep  = r_tkeep;
   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tlast  = r_tlast;
   assign busy          = (r_state == S_SEND);
   assign frames_sent   = r_frames;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: table of frames plus
// hand-written corner sequences, beats checked against a scoreboard.
module tb_axis_frame_source;

   logic        CLK = 1'b0;
   logic        resetn;
   logic        start;
   logic [15:0] frame_len;
   logic [1:0]  pattern;
   logic [7:0]  seed;
   logic        busy;
   logic [15:0] frames_sent;

   axis_frame_source_if #(.DATA_WIDTH(128)) vif ();

   axis_frame_source #(
      .DATA_WIDTH(128),
      .SAMPLE_WIDTH(8),
      .LEN_WIDTH(16)
   ) dut (
      .CLK(CLK),
      .resetn(resetn),
      .start(start),
      .frame_len(frame_len),
      .pattern(pattern),
      .seed(seed),
      .busy(busy),
      .frames_sent(frames_sent),
      .m_axis(vif.master)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [127:0] d;
      logic         last;
   } beat_t;

   typedef struct {
      int         len;
      logic [1:0] pat;
      logic [7:0] seed;
      int         pct;
      int         exp_frames;
   } vec_t;

   beat_t        sb_q[$];
   logic [127:0] cap_q[$];
   logic         cap_last[$];
   int           hs_cnt;
   int           tests = 0;
   int           fails = 0;
   int           exp_frames;

   logic         stall_prev = 1'b0;
   logic [127:0] prev_data;
   logic         prev_last;

   task automatic check(input string nm,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] model(input int n,
                                          input logic [1:0] p,
                                          input logic [7:0] s);
      logic [127:0] d;
      logic [7:0]   v;
      d = '0;
      for (int k = 0; k < 16; k++) begin
         case (p)
            2'd0:    v = s + 8'(16 * n + k);
            2'd1:    v = s;
            2'd2:    v = (k % 2 == 1) ? ~s : s;
            default: v = 8'(n);
         endcase
         d[8*k +: 8] = v;
      end
      return d;
   endfunction

   // Beat monitor: sampled mid-cycle, a valid&&ready seen here is
   // the handshake taken at the next rising edge.
   always @(negedge CLK) begin
      beat_t e;
      if (resetn) begin
         check("tkeep", {112'd0, vif.tkeep},
               vif.tvalid ? 128'hFFFF : 128'h0);
         if (vif.tvalid) begin
            if (stall_prev) begin
               check("stall_data", vif.tdata, prev_data);
               check("stall_last", {127'd0, vif.tlast},
                     {127'd0, prev_last});
            end
            if (vif.tready) begin
               if (sb_q.size() == 0) begin
                  check("extra_beat", {127'd0, vif.tvalid}, 128'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("beat_data", vif.tdata, e.d);
                  check("beat_last", {127'd0, vif.tlast},
                        {127'd0, e.last});
               end
               cap_q.push_back(vif.tdata);
               cap_last.push_back(vif.tlast);
               hs_cnt++;
            end
            stall_prev = !vif.tready;
            prev_data  = vif.tdata;
            prev_last  = vif.tlast;
         end else begin
            stall_prev = 1'b0;
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic launch(input int len, input logic [1:0] p,
                         input logic [7:0] s);
      cap_q.delete();
      cap_last.delete();
      hs_cnt    = 0;
      frame_len = 16'(len);
      pattern   = p;
      seed      = s;
      start     = 1'b1;
      for (int n = 0; n < len; n++)
         sb_q.push_back('{model(n, p, s), n == len - 1});
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int pct, output int vcyc);
      int guard;
      vcyc  = 0;
      guard = 0;
      while (busy && guard < 4000) begin
         if (vif.tvalid) vcyc++;
         vif.tready = (pct >= 100) ? 1'b1
                    : ($urandom_range(99) < pct);
         tick();
         guard++;
      end
      check("timeout_busy", {127'd0, busy}, 128'd0);
      vif.tready = 1'b1;
   endtask

   vec_t vecs[7];

   initial begin
      int vcyc;
      int nlast;

      vecs[0] = '{4,  2'd0, 8'h10, 100, 2};
      vecs[1] = '{3,  2'd3, 8'h00, 50,  3};
      vecs[2] = '{1,  2'd2, 8'hA5, 100, 4};
      vecs[3] = '{16, 2'd0, 8'hF8, 100, 5};
      vecs[4] = '{5,  2'd1, 8'h3C, 70,  6};
      vecs[5] = '{20, 2'd3, 8'h7E, 40,  7};
      vecs[6] = '{2,  2'd2, 8'h00, 100, 8};

      resetn     = 1'b0;
      start      = 1'b0;
      frame_len  = '0;
      pattern    = '0;
      seed       = '0;
      vif.tready = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_tvalid", {127'd0, vif.tvalid}, 128'd0);
         check("idle_busy", {127'd0, busy}, 128'd0);
         check("idle_frames", {112'd0, frames_sent}, 128'd0);
      end

      // Reset during beat 2 of an 8-beat frame
      vif.tready = 1'b1;
      launch(8, 2'd0, 8'h00);
      tick();
      tick();
      check("rst_beat2", vif.tdata, model(2, 2'd0, 8'h00));
      vif.tready = 1'b0;
      resetn     = 1'b0;
      tick();
      check("rst_tvalid", {127'd0, vif.tvalid}, 128'd0);
      check("rst_tlast", {127'd0, vif.tlast}, 128'd0);
      check("rst_tdata", vif.tdata, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_frames", {112'd0, frames_sent}, 128'd0);
      sb_q.delete();
      resetn     = 1'b1;
      vif.tready = 1'b1;
      tick();
      launch(8, 2'd0, 8'h00);
      wait_idle(100, vcyc);
      check("restart_beats", 128'(hs_cnt), 128'd8);
      check("restart_b0", {120'd0, cap_q[0][7:0]}, 128'd0);
      check("restart_frames", {112'd0, frames_sent}, 128'd1);

      for (int i = 0; i < 7; i++) begin
         launch(vecs[i].len, vecs[i].pat, vecs[i].seed);
         check("lat_tvalid", {127'd0, vif.tvalid}, 128'd1);
         check("lat_busy", {127'd0, busy}, 128'd1);
         wait_idle(vecs[i].pct, vcyc);
         check("hs_count", 128'(hs_cnt), 128'(vecs[i].len));
         check("frames", {112'd0, frames_sent},
               128'(vecs[i].exp_frames));
         if (vecs[i].pct >= 100)
            check("throughput", 128'(vcyc), 128'(vecs[i].len));
         nlast = 0;
         foreach (cap_last[j]) nlast += int'(cap_last[j]);
         check("tlast_count", 128'(nlast), 128'd1);
         check("end_tvalid", {127'd0, vif.tvalid}, 128'd0);
         check("end_tdata", vif.tdata, 128'd0);
         if (i == 0) begin
            check("ramp_b0", cap_q[0],
                  128'h1F1E1D1C1B1A19181716151413121110);
            check("ramp_b3", {120'd0, cap_q[3][7:0]}, 128'h40);
            check("ramp_last3", {127'd0, cap_last[3]}, 128'd1);
         end
         if (i == 1) begin
            for (int j = 0; j < 3; j++)
               check("bidx_lane", {120'd0, cap_q[j][7:0]},
                     128'(j));
         end
         if (i == 2) begin
            check("alt_beat", cap_q[0],
                  128'h5AA55AA55AA55AA55AA55AA55AA55AA5);
            check("alt_last", {127'd0, cap_last[0]}, 128'd1);
         end
         if (i == 3)
            check("ramp_wrap", {120'd0, cap_q[0][71:64]}, 128'd0);
      end
      exp_frames = 8;

      // Start pulsed mid-frame is dropped
      launch(6, 2'd0, 8'h20);
      tick();
      tick();
      frame_len = 16'd9;
      pattern   = 2'd1;
      seed      = 8'hEE;
      start     = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(100, vcyc);
      exp_frames++;
      check("mid_beats", 128'(hs_cnt), 128'd6);
      check("mid_frames", {112'd0, frames_sent}, 128'(exp_frames));
      repeat (4) tick();
      check("mid_noqueue", {127'd0, vif.tvalid}, 128'd0);
      check("mid_sb_empty", 128'(sb_q.size()), 128'd0);

      // Zero-length request is ignored
      frame_len = 16'd0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("zero_busy", {127'd0, busy}, 128'd0);
      repeat (3) tick();
      check("zero_tvalid", {127'd0, vif.tvalid}, 128'd0);
      check("zero_frames", {112'd0, frames_sent}, 128'(exp_frames));

      // Start coinciding with the last handshake, then minimum gap
      launch(2, 2'd1, 8'h55);
      tick();
      frame_len = 16'd3;
      start     = 1'b1;
      tick();
      start = 1'b0;
      exp_frames++;
      check("lastcyc_busy", {127'd0, busy}, 128'd0);
      check("lastcyc_tvalid", {127'd0, vif.tvalid}, 128'd0);
      check("lastcyc_frames", {112'd0, frames_sent},
            128'(exp_frames));
      launch(3, 2'd1, 8'h33);
      check("gap_tvalid", {127'd0, vif.tvalid}, 128'd1);
      wait_idle(100, vcyc);
      exp_frames++;
      check("gap_beats", 128'(hs_cnt), 128'd3);
      check("gap_frames", {112'd0, frames_sent}, 128'(exp_frames));
      check("final_sb_empty", 128'(sb_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
